pre_fft_buffer_rhiddi: RTL and testbench



---
 rtl/pulseox_fft_pkg.sv | 28 ++
 rtl/pingpong_ram_rhiddi.sv | 26 ++
 rtl/pre_fft_buffer_rhiddi.sv | 151 +++++++++++++++
 tb/tb_pre_fft_buffer_rhiddi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulseox_fft_pkg.sv
// Shared FFT-path definitions for the pulse-oximeter front end.
// Used by both the pre-FFT buffer and the post-FFT magnitude stage.
package pulseox_fft_pkg;

  localparam int FFT_N    = 1024;
  localparam int FFT_AW   = 10;
  localparam int SAMPLE_W = 22;
  localparam int FFT_W    = 2 * SAMPLE_W;
  localparam int REAL_LSB = 22;
  localparam int IMAG_LSB = 0;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rd_state_e;

  // Reverse the low aw bits of a
  function automatic logic [31:0] bitrev(
    input logic [31:0] a,
    input int          aw
  );
    logic [31:0] r;
    r = {<<{a}};
    return r >> (32 - aw);
  endfunction

endpackage

// File: rtl/pingpong_ram_rhiddi.sv
// Two-bank sample store: one write port, one synchronous read port.
// Bank select is the address MSB.
module pingpong_ram_rhiddi #(
  parameter int DW = 22,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW:0]   raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**(AW+1)];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pre_fft_buffer_rhiddi.sv
// Ping-pong frame buffer feeding PPG samples to the FFT core.
// Streams {real=sample, imag=0} words with a frame-start sync.
module pre_fft_buffer_rhiddi
  import pulseox_fft_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int AW      = FFT_AW,
  parameter int DW      = SAMPLE_W,
  parameter int BIT_REV = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   sample_in,
  input  logic            sample_valid,
  input  logic            fft_ready,
  output logic [2*DW-1:0] fft_data,
  output logic            fft_valid,
  output logic            fft_sync,
  output logic            frame_done,
  output logic            overrun
);

  rd_state_e     state_q;
  logic          wr_bank_q;
  logic [AW-1:0] wr_addr_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          overrun_q;
  logic          rd_bank_q;
  logic [AW:0]   fetch_q;
  logic [AW-1:0] out_idx_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          sync_q;
  logic          done_q;

  logic          wr_ok;
  logic          last_wr;
  logic          hs;
  logic          last_rd;
  logic          ren;
  logic [AW-1:0] raw_idx;
  logic [AW-1:0] ram_idx;
  logic [DW-1:0] ram_rdata;

  assign wr_ok   = sample_valid && !full_q[wr_bank_q];
  assign last_wr = wr_addr_q == AW'(N - 1);
  assign hs      = valid_q && fft_ready;
  assign last_rd = hs && (out_idx_q == AW'(N - 1));

  // fetch_q runs one word ahead of the presented word
  always_comb begin
    ren     = 1'b0;
    raw_idx = fetch_q[AW-1:0];
    unique case (state_q)
      RD_IDLE: begin
        ren     = full_q[rd_bank_q];
        raw_idx = '0;
      end
      RD_PRIME:  ren = 1'b1;
      RD_STREAM: ren = hs && !fetch_q[AW];
      default:   ren = 1'b0;
    endcase
  end

  assign ram_idx = (BIT_REV != 0) ?
    AW'(bitrev(32'(raw_idx), AW)) : raw_idx;

  always_comb begin
    full_d = full_q;
    if (wr_ok && last_wr) full_d[wr_bank_q] = 1'b1;
    if (last_rd) full_d[rd_bank_q] = 1'b0;
  end

  pingpong_ram_rhiddi #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i ({wr_bank_q, wr_addr_q}),
    .wdata_i (sample_in),
    .re_i    (ren),
    .raddr_i ({rd_bank_q, ram_idx}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RD_IDLE;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= '0;
      overrun_q <= 1'b0;
      rd_bank_q <= 1'b0;
      fetch_q   <= '0;
      out_idx_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_addr_q <= wr_addr_q + AW'(1);
        if (last_wr) wr_bank_q <= ~wr_bank_q;
      end
      if (sample_valid && !wr_ok) overrun_q <= 1'b1;
      full_q <= full_d;
      done_q <= 1'b0;
      unique case (state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            fetch_q <= (AW+1)'(1);
            state_q <= RD_PRIME;
          end
        end
        RD_PRIME: begin
          data_q    <= ram_rdata;
          valid_q   <= 1'b1;
          sync_q    <= 1'b1;
          out_idx_q <= '0;
          fetch_q   <= fetch_q + (AW+1)'(1);
          state_q   <= RD_STREAM;
        end
        RD_STREAM: begin
          if (hs) begin
            sync_q <= 1'b0;
            if (last_rd) begin
              valid_q   <= 1'b0;
              done_q    <= 1'b1;
              rd_bank_q <= ~rd_bank_q;
              state_q   <= RD_IDLE;
            end else begin
              data_q    <= ram_rdata;
              out_idx_q <= out_idx_q + AW'(1);
              if (!fetch_q[AW]) fetch_q <= fetch_q + (AW+1)'(1);
            end
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign fft_data   = {data_q, {DW{1'b0}}};
  assign fft_valid  = valid_q;
  assign fft_sync   = sync_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pre_fft_buffer_rhiddi.sv
// Scoreboard bench for pre_fft_buffer_rhiddi: N=8 plain and
// bit-reversed instances plus a full-size N=1024 instance.
module tb_pre_fft_buffer_rhiddi;

  localparam int DW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst8 = 1'b1, sv8 = 1'b0, rdy8 = 1'b0;
  logic [DW-1:0] sin8 = '0;
  logic [2*DW-1:0] d8;
  logic          v8, s8, fd8, ov8;

  logic          rstR = 1'b1, svR = 1'b0, rdyR = 1'b0;
  logic [DW-1:0] sinR = '0;
  logic [2*DW-1:0] dR;
  logic          vR, sR, fdR, ovR;

  logic          rstB = 1'b1, svB = 1'b0, rdyB = 1'b0;
  logic [DW-1:0] sinB = '0;
  logic [2*DW-1:0] dB;
  logic          vB, sB, fdB, ovB;

  pre_fft_buffer_rhiddi #(
    .N(8), .AW(3), .DW(DW), .BIT_REV(0)
  ) u_dut8 (
    .clk(clk), .reset(rst8), .sample_in(sin8),
    .sample_valid(sv8), .fft_ready(rdy8),
    .fft_data(d8), .fft_valid(v8), .fft_sync(s8),
    .frame_done(fd8), .overrun(ov8)
  );

  pre_fft_buffer_rhiddi #(
    .N(8), .AW(3), .DW(DW), .BIT_REV(1)
  ) u_rev8 (
    .clk(clk), .reset(rstR), .sample_in(sinR),
    .sample_valid(svR), .fft_ready(rdyR),
    .fft_data(dR), .fft_valid(vR), .fft_sync(sR),
    .frame_done(fdR), .overrun(ovR)
  );

  pre_fft_buffer_rhiddi #(
    .N(1024), .AW(10), .DW(DW), .BIT_REV(0)
  ) u_big (
    .clk(clk), .reset(rstB), .sample_in(sinB),
    .sample_valid(svB), .fft_ready(rdyB),
    .fft_data(dB), .fft_valid(vB), .fft_sync(sB),
    .frame_done(fdB), .overrun(ovB)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] q8[$];
  logic [DW-1:0] qR[$];
  logic [DW-1:0] qB[$];

  int cnt8 = 0, cntR = 0, cntB = 0;
  int done8 = 0, doneB = 0;
  bit mon_en8 = 1'b1;
  bit exp_fd8 = 1'b0;
  bit stall8 = 1'b0;
  bit gap_en = 1'b0;
  bit gap_arm = 1'b0;
  int gap8 = 0;
  logic [2*DW-1:0] pd8 = '0;
  logic ps8 = 1'b0;
  bit rnd_en = 1'b0;

  int rev_ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Monitor for the plain N=8 instance
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (mon_en8) begin
      chk("done8", 64'(fd8), 64'(exp_fd8));
      if (fd8) done8++;
      if (stall8) begin
        chk("hold_v8", 64'(v8), 64'd1);
        chk("hold_d8", 64'(d8), 64'(pd8));
        chk("hold_s8", 64'(s8), 64'(ps8));
      end
      if (gap_arm && v8) begin
        if (gap_en) chk("gap8", 64'(gap8), 64'd2);
        gap_arm = 1'b0;
      end else if (gap_arm) begin
        gap8++;
      end
      exp_fd8 = 1'b0;
      if (v8 && rdy8) begin
        chk("sb8_avail", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("data8", 64'(d8), 64'({e, {DW{1'b0}}}));
        end
        chk("sync8", 64'(s8), 64'(cnt8 == 0));
        if (cnt8 == 7) begin
          cnt8 = 0;
          exp_fd8 = 1'b1;
          gap_arm = 1'b1;
          gap8 = 0;
        end else begin
          cnt8++;
        end
      end
      stall8 = v8 && !rdy8;
      pd8 = d8;
      ps8 = s8;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (vR && rdyR) begin
      chk("sbR_avail", 64'(qR.size() > 0), 64'd1);
      if (qR.size() > 0) begin
        e = qR.pop_front();
        chk("dataR", 64'(dR), 64'({e, {DW{1'b0}}}));
      end
      chk("syncR", 64'(sR), 64'(cntR == 0));
      cntR = (cntR + 1) % 8;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (fdB) doneB++;
    if (vB && rdyB) begin
      chk("sbB_avail", 64'(qB.size() > 0), 64'd1);
      if (qB.size() > 0) begin
        e = qB.pop_front();
        chk("dataB", 64'(dB), 64'({e, {DW{1'b0}}}));
      end
      chk("syncB", 64'(sB), 64'(cntB == 0));
      cntB = (cntB + 1) % 1024;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      rdyB = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input int v, input bit keep);
    sin8 = DW'(v);
    sv8 = 1'b1;
    if (keep) q8.push_back(DW'(v));
    tick();
    sv8 = 1'b0;
  endtask

  task automatic drain8(input int lim);
    for (int c = 0; c < lim && q8.size() != 0; c++) tick();
    chk("drain8", 64'(q8.size()), 64'd0);
    repeat (4) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    repeat (3) tick();
    rst8 = 1'b0;
    rstR = 1'b0;
    rstB = 1'b0;
    chk("rst_v", 64'(v8), 64'd0);
    chk("rst_s", 64'(s8), 64'd0);
    chk("rst_fd", 64'(fd8), 64'd0);
    chk("rst_ov", 64'(ov8), 64'd0);
    chk("rst_d", 64'(d8), 64'd0);

    // basic frame and latency
    rdy8 = 1'b1;
    for (int i = 1; i <= 8; i++) drive8(i, 1'b1);
    @(negedge clk);
    chk("lat_c1", 64'(v8), 64'd0);
    @(negedge clk);
    chk("lat_c2", 64'(v8), 64'd0);
    @(negedge clk);
    chk("lat_c3_v", 64'(v8), 64'd1);
    chk("lat_c3_s", 64'(s8), 64'd1);
    #1;
    drain8(200);

    // backpressure on word 0 and word 3
    rdy8 = 1'b0;
    for (int i = 1; i <= 8; i++) drive8(i, 1'b1);
    for (int c = 0; c < 50 && !v8; c++) tick();
    chk("bp_v0", 64'(v8), 64'd1);
    repeat (5) tick();
    rdy8 = 1'b1;
    for (int c = 0; c < 50 && cnt8 != 3; c++) tick();
    chk("bp_at3", 64'(cnt8), 64'd3);
    rdy8 = 1'b0;
    repeat (5) tick();
    rdy8 = 1'b1;
    drain8(200);

    // ping-pong fill with overrun
    rdy8 = 1'b0;
    d0 = done8;
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) chk("ovr_pre", 64'(ov8), 64'd0);
      drive8(i, i <= 16);
    end
    chk("ovr_set", 64'(ov8), 64'd1);
    gap_en = 1'b1;
    rdy8 = 1'b1;
    drain8(400);
    gap_en = 1'b0;
    chk("pp_frames", 64'(done8 - d0), 64'd2);
    chk("ovr_sticky", 64'(ov8), 64'd1);

    // reset mid-stream at word 4
    rdy8 = 1'b1;
    for (int i = 1; i <= 8; i++) drive8(i, 1'b1);
    for (int c = 0; c < 50 && cnt8 != 4; c++) tick();
    chk("rs_at4", 64'(cnt8), 64'd4);
    mon_en8 = 1'b0;
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("rs_v", 64'(v8), 64'd0);
    chk("rs_ov", 64'(ov8), 64'd0);
    chk("rs_s", 64'(s8), 64'd0);
    chk("rs_fd", 64'(fd8), 64'd0);
    chk("rs_d", 64'(d8), 64'd0);
    q8.delete();
    cnt8 = 0;
    stall8 = 1'b0;
    exp_fd8 = 1'b0;
    gap_arm = 1'b0;
    mon_en8 = 1'b1;
    for (int i = 101; i <= 108; i++) drive8(i, 1'b1);
    drain8(200);

    // bit-reversed read order
    rdyR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sinR = DW'(i);
      svR = 1'b1;
      qR.push_back(DW'(rev_ord[i]));
      tick();
      svR = 1'b0;
    end
    for (int c = 0; c < 200 && qR.size() != 0; c++) tick();
    chk("drainR", 64'(qR.size()), 64'd0);
    chk("ovR", 64'(ovR), 64'd0);

    // full-size ramp, 3 frames, random ready
    rnd_en = 1'b1;
    for (int i = 0; i < 3072; i++) begin
      sinB = DW'(32'h3FFC00 + i);
      svB = 1'b1;
      qB.push_back(DW'(32'h3FFC00 + i));
      tick();
      svB = 1'b0;
      repeat (3) tick();
    end
    for (int c = 0; c < 20000 && qB.size() != 0; c++) tick();
    rnd_en = 1'b0;
    repeat (4) tick();
    chk("drainB", 64'(qB.size()), 64'd0);
    chk("doneB", 64'(doneB), 64'd3);
    chk("ovB", 64'(ovB), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
